// File: rtl/apb_cmd_master.sv
// APB3 requester: turns a cmd/rsp handshake into single APB transfers with timeout.
// Latency: accept -> SETUP next cycle; rsp_valid one cycle after PREADY edge (misaligned: next cycle).
// Backpressure: cmd_ready only high in IDLE; one transfer in flight, no buffering, rsp not stallable.
module apb_cmd_master #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Wait counter only needs to reach TIMEOUT_CYCLES-1.
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_timeout_q, rsp_timeout_d;

    // Next-state logic; every output flop is a function of the next state so outputs stay registered.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_addr[1:0] == 2'b00) begin
                        state_d  = ST_SETUP;
                        pwrite_d = cmd_write;
                        paddr_d  = cmd_addr;
                        pwdata_d = cmd_write ? cmd_wdata : '0;
                        cnt_d    = '0;
                    end else begin
                        // Misaligned: answer with an error, never touch the bus.
                        state_d       = ST_RESP;
                        rsp_rdata_d   = '0;
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b0;
                    end
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
                cnt_d   = '0;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    // Completion takes priority over a watchdog expiring on the same edge.
                    state_d       = ST_RESP;
                    rsp_err_d     = PSLVERR;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = (!pwrite_q && !PSLVERR) ? PRDATA : '0;
                end else if (WDOG_EN && (cnt_q == CNT_LAST)) begin
                    state_d       = ST_RESP;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                end else if (WDOG_EN) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
        psel_d      = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
        penable_d   = (state_d == ST_ACCESS);
        rsp_valid_d = (state_d == ST_RESP);
    end

    // State and output registers; reset drops the bus at once and discards any transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            cmd_ready_q   <= 1'b1;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cmd_ready_q   <= cmd_ready_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Scoreboard bench for apb_cmd_master with a wait-state/error APB slave model.
// Expected responses come from a transaction-level model pushed at issue time.
// Separate monitors check responses, latency and APB protocol/stability.
module tb_apb_cmd_master;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA;
    logic [31:0] PRDATA = '0;
    logic        PREADY = 1'b0;
    logic        PSLVERR = 1'b0;

    apb_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        to;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb_q[$];
    int   pen_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Slave plan for the command in flight, and the command itself.
    int          plan_waits = 0;
    logic        plan_err   = 1'b0;
    logic [31:0] plan_rdata = '0;
    logic        cur_wr     = 1'b0;
    logic [31:0] cur_addr   = '0;
    logic [31:0] cur_wd     = '0;
    logic        cur_mis    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // APB slave: assert PREADY after plan_waits wait states of the ACCESS phase.
    int acc_cnt = 0;
    always @(negedge clk) begin
        if (rst_n && PSEL && PENABLE) begin
            PREADY  = (acc_cnt == plan_waits);
            PSLVERR = (acc_cnt == plan_waits) ? plan_err : 1'b0;
            PRDATA  = plan_rdata;
            acc_cnt++;
        end else begin
            PREADY  = 1'b0;
            PSLVERR = 1'b0;
            PRDATA  = $urandom();
            acc_cnt = 0;
        end
    end

    // Response monitor: pop expected response whenever the DUT strobes rsp_valid.
    bit rdy_next = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            rdy_next = 0;
        end else begin
            if (rdy_next) begin
                chk("cmd_ready_after_rsp", {31'b0, cmd_ready}, 32'd1);
                rdy_next = 0;
            end
            if (rsp_valid) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
                    chk("rsp_timeout", {31'b0, rsp_timeout}, {31'b0, e.to});
                    chk("rsp_latency", cyc - e.acc, e.lat);
                    chk("rsp_cycle_bus_idle", {30'b0, PSEL, PENABLE}, 32'd0);
                    chk("rsp_cycle_cmd_ready", {31'b0, cmd_ready}, 32'd0);
                    rdy_next = 1;
                end
            end
        end
    end

    // Protocol monitor: stable SETUP/ACCESS signals and ACCESS-phase length.
    int pen_cnt = 0;
    always @(negedge clk) begin
        int want;
        if (!rst_n) begin
            pen_cnt = 0;
        end else begin
            if (PENABLE) chk("penable_without_psel", {31'b0, PSEL}, 32'd1);
            if (PSEL) begin
                chk("psel_on_misaligned", {31'b0, cur_mis}, 32'd0);
                chk("paddr", PADDR, cur_addr);
                chk("pwrite", {31'b0, PWRITE}, {31'b0, cur_wr});
                chk("pwdata", PWDATA, cur_wr ? cur_wd : 32'd0);
            end
            if (PSEL && PENABLE) begin
                pen_cnt++;
            end else if (pen_cnt != 0) begin
                want = (pen_q.size() != 0) ? pen_q.pop_front() : -1;
                chk("access_cycles", pen_cnt, want);
                pen_cnt = 0;
            end
        end
    end

    // Issue one command (called at a negedge) and record the model's expectation.
    task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input int waits, input logic serr, input logic [31:0] rd,
                        input bit expect_rsp);
        int   guard = 0;
        exp_t e;
        while (!cmd_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!cmd_ready) begin
            chk("cmd_ready_wait", 32'd0, 32'd1);
            return;
        end
        plan_waits = waits;
        plan_err   = serr;
        plan_rdata = rd;
        cur_wr     = wr;
        cur_addr   = addr;
        cur_wd     = wd;
        cur_mis    = (addr[1:0] != 2'b00);
        cmd_valid  = 1'b1;
        cmd_write  = wr;
        cmd_addr   = addr;
        cmd_wdata  = wd;
        if (cur_mis) begin
            e.rdata = 32'd0; e.err = 1'b1; e.to = 1'b0; e.lat = 0;
        end else if (waits >= TO) begin
            e.rdata = 32'd0; e.err = 1'b1; e.to = 1'b1; e.lat = 1 + TO;
        end else begin
            e.rdata = (wr || serr) ? 32'd0 : rd;
            e.err   = serr;
            e.to    = 1'b0;
            e.lat   = 2 + waits;
        end
        @(posedge clk);
        #1;
        e.acc = cyc;
        if (expect_rsp) begin
            sb_q.push_back(e);
            if (!cur_mis) pen_q.push_back((waits >= TO) ? TO : waits + 1);
        end
        cmd_valid = 1'b0;
        cmd_write = $urandom_range(0, 1);
        cmd_addr  = $urandom();
        cmd_wdata = $urandom();
        @(negedge clk);
    endtask

    initial begin
        int g;
        int sel;
        int w;
        logic [31:0] a;

        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        chk("rst_bus", {29'b0, PSEL, PENABLE, PWRITE}, 32'd0);
        chk("rst_paddr", PADDR, 32'd0);
        chk("rst_pwdata", PWDATA, 32'd0);
        chk("rst_rsp", {29'b0, rsp_valid, rsp_err, rsp_timeout}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases.
        send(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 1'b0, 32'h0, 1);
        send(1'b0, 32'h0000_0004, 32'h0, 3, 1'b0, 32'h1234_5678, 1);
        send(1'b1, 32'h0000_0020, 32'hCAFE_0001, 1, 1'b1, 32'h0, 1);
        send(1'b1, 32'h0000_0024, 32'hCAFE_0002, 0, 1'b0, 32'h0, 1);
        send(1'b0, 32'h0000_0008, 32'h0, 100, 1'b0, 32'h5555_AAAA, 1);
        send(1'b0, 32'h0000_000C, 32'h0, TO - 1, 1'b0, 32'h0BAD_F00D, 1);
        send(1'b0, 32'h0000_0006, 32'h0, 0, 1'b0, 32'h0, 1);
        send(1'b0, 32'h0000_0030, 32'h0, 0, 1'b1, 32'hFFFF_FFFF, 1);

        // Reset in the middle of ACCESS: bus drops, no response.
        send(1'b1, 32'h0000_0040, 32'h0101_0101, 100, 1'b0, 32'h0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_bus", {30'b0, PSEL, PENABLE}, 32'd0);
        chk("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("mid_rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(1'b0, 32'h0000_0044, 32'h0, 2, 1'b0, 32'h7777_0000, 1);

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 5)      w = $urandom_range(0, 3);
            else if (sel == 6) w = TO - 1;
            else if (sel == 7) w = TO;
            else if (sel == 8) w = 30;
            else               w = $urandom_range(4, 6);
            a = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(0, 5) == 0) a = a | 32'($urandom_range(1, 3));
            send(1'($urandom_range(0, 1)), a, $urandom(), w,
                 1'($urandom_range(0, 3) == 0), $urandom(), 1);
        end

        g = 0;
        while ((sb_q.size() != 0 || pen_q.size() != 0) && g < 300) begin
            @(negedge clk);
            g++;
        end
        repeat (2) @(negedge clk);
        chk("sb_drained", sb_q.size(), 32'd0);
        chk("pen_drained", pen_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
